sensor_level_encoder: RTL and testbench
=======================================

Name: sensor_level_encoder

Overview:
Front-end that turns raw 8-bit rain, seismic, wind and water-level readings into the 2-bit severity codes (r1 r0, s1 s0, w1 w0, l1 l0) that the disaster detection logic consumes. Each channel has its own quantiser with threshold hysteresis and a consecutive-sample debounce filter. The block sits between the sensor sampling interface and the detection/priority logic. All outputs are registered.

Parameters:
TH1, 64, raw value at or above which level 01 is reached
TH2, 128, raw value at or above which level 10 is reached
TH3, 192, raw value at or above which level 11 is reached
HYST, 8, hysteresis margin applied to downward transitions only
DEB, 3, number of consecutive valid samples a new level must persist before it is committed (legal range 1 to 2^CNT_W-1)
CNT_W, 4, width of the debounce counters
Legality: TH1 < TH2 < TH3 <= 255.

Ports:
clk  in  1  single clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
sample_valid  in  1  the raw inputs hold a new sample this cycle
rain  in  8  raw rainfall reading
seismic  in  8  raw seismic reading
wind  in  8  raw wind-speed reading
water  in  8  raw water-level reading
r1, r0  out  1 each  committed rain level, with r1 as the MSB
s1, s0  out  1 each  committed seismic level
w1, w0  out  1 each  committed wind level
l1, l0  out  1 each  committed water level
levels_valid  out  1  one-cycle pulse the cycle after each accepted sample
level_change  out  1  one-cycle pulse the cycle after any channel commits a new level

Behaviour:
- Reset (synchronous, active-high; wins over sample_valid):
  - all level outputs 00.
  - levels_valid = 0, level_change = 0.
  - every pending level = 00, every debounce counter = 0.
  - rst asserted mid-debounce discards the partial count.
- Accepted sample: sample_valid = 1 while rst = 0. When sample_valid = 0, all state holds and both pulse outputs are 0.
- Quantise function q(x):
  - x >= TH3 gives 3.
  - else x >= TH2 gives 2.
  - else x >= TH1 gives 1.
  - else 0.
- Per channel, with L = committed level and raw = channel input:
  - up = q(raw).
  - dn = q(min(raw + HYST, 255)); compute the sum 9 bits wide and saturate to 255.
  - candidate = up if up > L; else dn if dn < L; else L.
- Debounce, per channel, on each accepted sample:
  - candidate == L: counter <= 0.
  - candidate != L and candidate != pending: pending <= candidate, counter <= 1. If DEB == 1, commit immediately instead.
  - candidate != L and candidate == pending: counter <= counter + 1.
  - Commit: when the post-update count equals DEB, L <= pending and counter <= 0. The counter never exceeds DEB.
- Latency: a new level is visible on the outputs in the cycle after the DEB-th consecutive accepted sample. Non-valid cycles between samples do not break the run.
- levels_valid: asserted the cycle after every accepted sample, whether or not any level changed.
- level_change: asserted the cycle after any channel commits; a single pulse even if several channels commit together.
- Channels are fully independent; simultaneous commits on all four channels are legal.
- A multi-step jump (00 to 11) commits directly and never passes through the intermediate levels.

Test Plan:
- Reset: rst = 1 for 2 cycles with sample_valid = 1 and all inputs 255 -> all levels 00, levels_valid = 0, level_change = 0. First accepted sample after rst drops -> levels_valid pulses 1 cycle later.
- Rising commit: rain = 200 on 3 consecutive valid cycles -> {r1,r0} stays 00 after samples 1 and 2, becomes 11 the cycle after sample 3. level_change pulses exactly once; other channels stay 00.
- Glitch rejection: rain sequence 130, 130, 20, 130, 130, 130 -> no commit until after the 6th sample, then {r1,r0} = 10. Only one level_change pulse.
- Hysteresis: with rain committed at 10, apply rain = 125 for 5 samples -> stays 10 (125 + 8 >= 128). Then rain = 119 for 3 samples -> 01 after the 3rd. Wind = 250 with HYST saturation -> no wrap, level 11 holds.
- Valid gaps: wind = 200 on valid cycles interleaved with sample_valid = 0 cycles carrying wind = 0 -> {w1,w0} = 11 after the 3rd valid sample. The invalid cycles are ignored and levels_valid pulses only after valid samples.
- Simultaneous channels plus mid-operation reset:
  - All four inputs = 150 for 3 samples -> all levels 10 together, with a single level_change pulse.
  - Separately, rst asserted after 2 of 3 samples at 200, then 2 more samples -> still 00; a 3rd post-reset sample commits 11.

Source files
------------

// File: rtl/sensor_level_encoder_if.sv
// sensor_level_encoder_if: raw sensor samples in, committed 2-bit severity levels out
interface sensor_level_encoder_if;
    logic       sample_valid;
    logic [7:0] rain;
    logic [7:0] seismic;
    logic [7:0] wind;
    logic [7:0] water;
    logic       r1, r0, s1, s0, w1, w0, l1, l0;
    logic       levels_valid;
    logic       level_change;
    modport master (
        output sample_valid, rain, seismic, wind, water,
        input  r1, r0, s1, s0, w1, w0, l1, l0, levels_valid, level_change
    );
    modport slave (
        input  sample_valid, rain, seismic, wind, water,
        output r1, r0, s1, s0, w1, w0, l1, l0, levels_valid, level_change
    );
endinterface

// File: rtl/sensor_level_encoder.sv
// sensor_level_encoder: per-channel hysteresis quantiser with consecutive-sample debounce
module sensor_level_encoder #(
    parameter int TH1   = 64,
    parameter int TH2   = 128,
    parameter int TH3   = 192,
    parameter int HYST  = 8,
    parameter int DEB   = 3,
    parameter int CNT_W = 4
) (
    input logic                  clk,
    input logic                  rst,
    sensor_level_encoder_if.slave bus
);
    function automatic logic [1:0] q(input logic [7:0] x);
        return x >= 8'(TH3) ? 2'd3 : x >= 8'(TH2) ? 2'd2 : x >= 8'(TH1) ? 2'd1 : 2'd0;
    endfunction
    logic [3:0][7:0] raw;
    logic [3:0][1:0] lvl;
    logic [3:0]      commit;
    logic            lv_q, lc_q;
    assign raw = {bus.water, bus.wind, bus.seismic, bus.rain};
    for (genvar c = 0; c < 4; c++) begin : g_ch
        logic [1:0]       l_q, p_q, up, dn, cand;
        logic [CNT_W-1:0] n_q, inc;
        logic [8:0]       sum;
        assign sum  = {1'b0, raw[c]} + 9'(HYST);
        assign up   = q(raw[c]);
        assign dn   = q(sum[8] ? 8'hff : sum[7:0]);
        assign cand = up > l_q ? up : dn < l_q ? dn : l_q;
        assign inc  = n_q + 1'b1;
        assign commit[c] = bus.sample_valid && cand != l_q &&
                           (cand != p_q ? DEB == 1 : inc == CNT_W'(DEB));
        assign lvl[c] = l_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                l_q <= '0;
                p_q <= '0;
                n_q <= '0;
            end else if (bus.sample_valid) begin
                if (commit[c]) begin
                    l_q <= cand;
                    p_q <= cand;
                    n_q <= '0;
                end else if (cand == l_q) begin
                    n_q <= '0;
                end else if (cand != p_q) begin
                    p_q <= cand;
                    n_q <= CNT_W'(1);
                end else begin
                    n_q <= inc;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            lv_q <= 1'b0;
            lc_q <= 1'b0;
        end else begin
            lv_q <= bus.sample_valid;
            lc_q <= |commit;
        end
    end
    assign {bus.r1, bus.r0} = lvl[0];
    assign {bus.s1, bus.s0} = lvl[1];
    assign {bus.w1, bus.w0} = lvl[2];
    assign {bus.l1, bus.l0} = lvl[3];
    assign bus.levels_valid = lv_q;
    assign bus.level_change = lc_q;
endmodule

// File: tb/tb_sensor_level_encoder.sv
// tb_sensor_level_encoder: directed scenarios plus randomized run against a behavioural model
module tb_sensor_level_encoder;
    localparam int DEB = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   ml [4];
    int   mp [4];
    int   mn [4];
    logic lv_e, lc_e;
    sensor_level_encoder_if bus ();
    sensor_level_encoder dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic int qz(input int x);
        return x >= 192 ? 3 : x >= 128 ? 2 : x >= 64 ? 1 : 0;
    endfunction

    function automatic logic [9:0] got();
        return {bus.levels_valid, bus.level_change, bus.r1, bus.r0, bus.s1, bus.s0,
                bus.w1, bus.w0, bus.l1, bus.l0};
    endfunction

    function automatic logic [9:0] expv();
        return {lv_e, lc_e, 2'(ml[0]), 2'(ml[1]), 2'(ml[2]), 2'(ml[3])};
    endfunction

    task automatic model(input logic r, input logic v, input int x [4]);
        int up, dn, cand;
        logic chg;
        chg = 1'b0;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                ml[i] = 0; mp[i] = 0; mn[i] = 0;
            end
            lv_e = 1'b0; lc_e = 1'b0;
            return;
        end
        if (v) begin
            for (int i = 0; i < 4; i++) begin
                up = qz(x[i]);
                dn = qz(x[i] + 8 > 255 ? 255 : x[i] + 8);
                cand = up > ml[i] ? up : dn < ml[i] ? dn : ml[i];
                if (cand == ml[i]) mn[i] = 0;
                else begin
                    if (cand != mp[i]) begin mp[i] = cand; mn[i] = 1; end
                    else mn[i]++;
                    if (mn[i] == DEB) begin ml[i] = mp[i]; mn[i] = 0; chg = 1'b1; end
                end
            end
        end
        lv_e = v;
        lc_e = chg;
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] a, b, c, d);
        int x [4];
        @(negedge clk);
        rst = r;
        bus.sample_valid = v;
        bus.rain = a; bus.seismic = b; bus.wind = c; bus.water = d;
        x[0] = a; x[1] = b; x[2] = c; x[3] = d;
        @(posedge clk);
        model(r, v, x);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 255, 255, 255, 255);
            checks++;
            if (got() !== 10'b0) begin
                errors++; $display("FAIL reset_%0d got %b exp %b", i, got(), 10'b0);
            end
        end
        step(0, 1, 0, 0, 0, 0);
        checks++;
        if (got() !== 10'b10_0000_0000) begin
            errors++; $display("FAIL reset_first_valid got %b exp %b", got(), 10'b10_0000_0000);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.levels_valid !== 1'b0) begin
            errors++; $display("FAIL reset_idle got lv=%b exp 0", bus.levels_valid);
        end
    endtask

    task automatic test_rise;
        int pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 200, 0, 0, 0);
            pulses += int'(bus.level_change);
            checks++;
            if (got() !== expv()) begin
                errors++; $display("FAIL rise_%0d got %b exp %b", i, got(), expv());
            end
        end
        checks++;
        if (got() !== 10'b11_1100_0000 || pulses != 1) begin
            errors++; $display("FAIL rise_final got %b pulses %0d exp %b pulses 1", got(), pulses, 10'b11_1100_0000);
        end
    endtask

    task automatic test_glitch;
        logic [7:0] seq [6] = '{130, 130, 20, 130, 130, 130};
        int pulses = 0;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, seq[i], 0, 0, 0);
            pulses += int'(bus.level_change);
            checks++;
            if (got() !== expv() || {bus.r1, bus.r0} !== (i == 5 ? 2'b10 : 2'b00)) begin
                errors++; $display("FAIL glitch_%0d got %b exp %b", i, got(), expv());
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL glitch_pulses got %0d exp 1", pulses);
        end
    endtask

    task automatic test_hyst;
        int pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 125, 0, 0, 0);
            pulses += int'(bus.level_change);
        end
        checks++;
        if ({bus.r1, bus.r0} !== 2'b10 || pulses != 0) begin
            errors++; $display("FAIL hyst_hold got r=%b pulses %0d exp r=10 pulses 0", {bus.r1, bus.r0}, pulses);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 119, 0, 0, 0);
            checks++;
            if (got() !== expv() || {bus.r1, bus.r0} !== (i == 2 ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL hyst_drop_%0d got %b exp %b", i, got(), expv());
            end
        end
        for (int i = 0; i < 3; i++) step(0, 1, 119, 0, 250, 0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 119, 0, 250, 0);
            pulses += int'(bus.level_change);
        end
        checks++;
        if ({bus.w1, bus.w0} !== 2'b11 || pulses != 0 || got() !== expv()) begin
            errors++; $display("FAIL hyst_sat got %b pulses %0d exp %b pulses 0", got(), pulses, expv());
        end
    endtask

    task automatic test_gaps;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, i % 2 == 0, 0, 0, i % 2 == 0 ? 8'd200 : 8'd0, 0);
            checks++;
            if (got() !== expv() || bus.levels_valid !== (i % 2 == 0)) begin
                errors++; $display("FAIL gaps_%0d got %b exp %b", i, got(), expv());
            end
        end
        checks++;
        if ({bus.w1, bus.w0} !== 2'b11) begin
            errors++; $display("FAIL gaps_final got w=%b exp 11", {bus.w1, bus.w0});
        end
    endtask

    task automatic test_simul;
        int pulses = 0;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 150, 150, 150, 150);
            pulses += int'(bus.level_change);
        end
        checks++;
        if (got() !== 10'b11_1010_1010 || pulses != 1) begin
            errors++; $display("FAIL simul got %b pulses %0d exp %b pulses 1", got(), pulses, 10'b11_1010_1010);
        end
    endtask

    task automatic test_mid_reset;
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 200, 0, 0, 0);
        step(0, 1, 200, 0, 0, 0);
        step(1, 1, 200, 0, 0, 0);
        step(0, 1, 200, 0, 0, 0);
        step(0, 1, 200, 0, 0, 0);
        checks++;
        if ({bus.r1, bus.r0} !== 2'b00 || bus.level_change !== 1'b0) begin
            errors++; $display("FAIL midrst_partial got %b exp r=00", got());
        end
        step(0, 1, 200, 0, 0, 0);
        checks++;
        if (got() !== 10'b11_1100_0000) begin
            errors++; $display("FAIL midrst_commit got %b exp %b", got(), 10'b11_1100_0000);
        end
    endtask

    task automatic test_random;
        logic [7:0] x [4];
        int bad = 0;
        for (int i = 0; i < 4; i++) x[i] = 8'($urandom_range(0, 255));
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 4) == 0)
                    x[i] = $urandom_range(0, 1) == 1 ? 8'($urandom_range(0, 255))
                                                     : 8'(64 * $urandom_range(1, 3) + $urandom_range(0, 16) - 9);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, x[0], x[1], x[2], x[3]);
            checks++;
            if (got() !== expv()) begin
                errors++; bad++;
                if (bad <= 10) $display("FAIL random_%0d got %b exp %b", n, got(), expv());
            end
        end
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.rain = '0; bus.seismic = '0; bus.wind = '0; bus.water = '0;
        for (int i = 0; i < 4; i++) begin ml[i] = 0; mp[i] = 0; mn[i] = 0; end
        lv_e = 1'b0; lc_e = 1'b0;
        test_reset();
        test_rise();
        test_glitch();
        test_hyst();
        test_gaps();
        test_simul();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
